// File: rtl/seg_sched_pkg.sv
// Shared definitions for the segment-display frame scheduler:
// FSM encoding, default timing parameters and the blink masking helper.
package seg_sched_pkg;

    localparam int NUM_REQ       = 3;
    localparam int DEF_SHIFT_LEN = 64;
    localparam int DEF_GAP_LEN   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // A blinking digit is blanked while the blink phase is high.
    function automatic logic [7:0] blink_mask(input logic [7:0] les,
                                              input logic [7:0] blink,
                                              input logic       phase);
        return les & ~(blink & {8{phase}});
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: the search starts one past the last winner.
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] winner,
    output logic [1:0] index
);

    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // Rotate the priority order and pick the first active requester.
    always_comb begin
        first_s  = 2'd0;
        second_s = 2'd1;
        third_s  = 2'd2;
        winner   = 3'b000;
        index    = last;
        case (last)
            2'd0: begin
                first_s  = 2'd1;
                second_s = 2'd2;
                third_s  = 2'd0;
            end
            2'd1: begin
                first_s  = 2'd2;
                second_s = 2'd0;
                third_s  = 2'd1;
            end
            default: begin
                first_s  = 2'd0;
                second_s = 2'd1;
                third_s  = 2'd2;
            end
        endcase
        if (req[first_s]) begin
            index  = first_s;
            winner = 3'b001 << first_s;
        end else if (req[second_s]) begin
            index  = second_s;
            winner = 3'b001 << second_s;
        end else if (req[third_s]) begin
            index  = third_s;
            winner = 3'b001 << third_s;
        end else begin
            index  = last;
            winner = 3'b000;
        end
    end

endmodule

// File: rtl/seg_frame_sched.sv
// Frame scheduler feeding a segment-display serializer from three requesters,
// with round-robin arbitration and automatic refresh frames for blinking digits.
module seg_frame_sched
    import seg_sched_pkg::*;
#(
    parameter int SHIFT_LEN = DEF_SHIFT_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [95:0] hexs_in,
    input  logic [23:0] les_in,
    input  logic [23:0] points_in,
    input  logic [23:0] blink_in,
    input  logic        blink_tick,
    output logic [31:0] HEXS,
    output logic [7:0]  LES,
    output logic [7:0]  POINTS,
    output logic        load,
    output logic [2:0]  grant,
    output logic        busy
);

    localparam int CNT_MAX = (SHIFT_LEN > GAP_LEN) ? SHIFT_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [1:0]         last_r;
    logic               phase_r;
    logic               pend_r;
    logic               sent_r;
    logic [31:0]        hexs_r;
    logic [7:0]         les_r;
    logic [7:0]         points_r;
    logic               load_r;
    logic [2:0]         grant_r;
    logic               busy_r;

    logic [2:0]         win_onehot_s;
    logic [1:0]         win_idx_s;
    logic [31:0]        sel_hexs_s;
    logic [7:0]         sel_les_s;
    logic [7:0]         sel_points_s;
    logic [7:0]         sel_blink_s;
    logic               busy_s;
    logic               tick_refresh_s;

    rr_arb3 u_arb (
        .req    (req),
        .last   (last_r),
        .winner (win_onehot_s),
        .index  (win_idx_s)
    );

    // Route the most recently granted requester's inputs to the frame latch.
    always_comb begin
        sel_hexs_s   = hexs_in[95:64];
        sel_les_s    = les_in[23:16];
        sel_points_s = points_in[23:16];
        sel_blink_s  = blink_in[23:16];
        case (last_r)
            2'd0: begin
                sel_hexs_s   = hexs_in[31:0];
                sel_les_s    = les_in[7:0];
                sel_points_s = points_in[7:0];
                sel_blink_s  = blink_in[7:0];
            end
            2'd1: begin
                sel_hexs_s   = hexs_in[63:32];
                sel_les_s    = les_in[15:8];
                sel_points_s = points_in[15:8];
                sel_blink_s  = blink_in[15:8];
            end
            default: begin
                sel_hexs_s   = hexs_in[95:64];
                sel_les_s    = les_in[23:16];
                sel_points_s = points_in[23:16];
                sel_blink_s  = blink_in[23:16];
            end
        endcase
    end

    // Next-state and cycle counter for the frame sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if ((req != 3'b000) || pend_r) begin
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                state_s = ST_SHIFT;
                cnt_s   = CNT_W'(SHIFT_LEN - 1);
            end
            ST_SHIFT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_GAP;
                    cnt_s   = CNT_W'(GAP_LEN - 1);
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // A blink tick only needs a refresh when the shown requester actually blinks.
    always_comb begin
        busy_s = (state_s == ST_LATCH) || (state_s == ST_LOAD) || (state_s == ST_SHIFT);
        tick_refresh_s = blink_tick && (sent_r || (state_r == ST_LATCH)) &&
                         (sel_blink_s != 8'h00);
    end

    // State, arbitration record, frame latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            last_r   <= 2'd2;
            phase_r  <= 1'b0;
            pend_r   <= 1'b0;
            sent_r   <= 1'b0;
            hexs_r   <= 32'h0000_0000;
            les_r    <= 8'h00;
            points_r <= 8'h00;
            load_r   <= 1'b0;
            grant_r  <= 3'b000;
            busy_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            load_r  <= (state_s == ST_LOAD);
            busy_r  <= busy_s;

            // Arbitration is resolved on the way into LATCH, so grant lands in LATCH.
            if ((state_r == ST_IDLE) && (req != 3'b000)) begin
                grant_r <= win_onehot_s;
                last_r  <= win_idx_s;
            end else begin
                grant_r <= 3'b000;
            end

            if (state_r == ST_LATCH) begin
                hexs_r   <= sel_hexs_s;
                points_r <= sel_points_s;
                les_r    <= blink_mask(sel_les_s, sel_blink_s, phase_r);
                sent_r   <= 1'b1;
            end

            if (blink_tick) begin
                phase_r <= ~phase_r;
            end

            if (tick_refresh_s) begin
                pend_r <= 1'b1;
            end else if (state_r == ST_LATCH) begin
                pend_r <= 1'b0;
            end
        end
    end

    assign HEXS   = hexs_r;
    assign LES    = les_r;
    assign POINTS = points_r;
    assign load   = load_r;
    assign grant  = grant_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_seg_frame_sched.sv
// Self-checking bench for seg_frame_sched: a timeline-level frame model plus
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg_frame_sched;

    localparam int S = 64;
    localparam int G = 4;
    localparam int FRAME = 3 + S + G;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [95:0] hexs_in;
    logic [23:0] les_in;
    logic [23:0] points_in;
    logic [23:0] blink_in;
    logic        blink_tick;
    logic [31:0] HEXS;
    logic [7:0]  LES;
    logic [7:0]  POINTS;
    logic        load;
    logic [2:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    seg_frame_sched #(.SHIFT_LEN(S), .GAP_LEN(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .hexs_in    (hexs_in),
        .les_in     (les_in),
        .points_in  (points_in),
        .blink_in   (blink_in),
        .blink_tick (blink_tick),
        .HEXS       (HEXS),
        .LES        (LES),
        .POINTS     (POINTS),
        .load       (load),
        .grant      (grant),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: a frame is a fixed timeline counted from the idle cycle that starts it.
    // m_age is the age of the upcoming cycle: 1 latch, 2 load, 3..2+S shift, then gap.
    bit          m_in_frame;
    int          m_age;
    int          m_last;
    bit          m_phase;
    bit          m_pend;
    bit          m_sent;
    logic [31:0] m_hexs;
    logic [7:0]  m_les;
    logic [7:0]  m_points;
    logic [2:0]  e_grant;
    bit          e_load;
    bit          e_busy;

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int i = 1; i <= 3; i++) begin
            if (r[(last + i) % 3]) return (last + i) % 3;
        end
        return last;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_age      = 0;
        m_last     = 2;
        m_phase    = 1'b0;
        m_pend     = 1'b0;
        m_sent     = 1'b0;
        m_hexs     = 32'h0;
        m_les      = 8'h00;
        m_points   = 8'h00;
        e_grant    = 3'b000;
        e_load     = 1'b0;
        e_busy     = 1'b0;
    endtask

    task automatic model_update();
        bit latch_now;
        bit tick_set;
        bit old_pend;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_pend  = m_pend;
        latch_now = m_in_frame && (m_age == 1);
        tick_set  = blink_tick && (m_sent || latch_now) &&
                    (blink_in[8*m_last +: 8] != 8'h00);
        if (latch_now) begin
            m_hexs   = hexs_in[32*m_last +: 32];
            m_points = points_in[8*m_last +: 8];
            m_les    = les_in[8*m_last +: 8] & ~(blink_in[8*m_last +: 8] & {8{m_phase}});
            m_sent   = 1'b1;
        end
        if (tick_set) m_pend = 1'b1;
        else if (latch_now) m_pend = 1'b0;
        if (blink_tick) m_phase = !m_phase;
        e_grant = 3'b000;
        if (!m_in_frame) begin
            if ((req != 3'b000) || old_pend) begin
                m_in_frame = 1'b1;
                m_age      = 1;
                if (req != 3'b000) begin
                    m_last  = rr_pick(req, m_last);
                    e_grant = 3'(1 << m_last);
                end
            end
        end else begin
            m_age++;
            if (m_age == FRAME) begin
                m_in_frame = 1'b0;
                m_age      = 0;
            end
        end
        e_load = m_in_frame && (m_age == 2);
        e_busy = m_in_frame && (m_age >= 1) && (m_age <= 2 + S);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic compare();
        check("grant",  32'(grant),  32'(e_grant));
        check("load",   32'(load),   32'(e_load));
        check("busy",   32'(busy),   32'(e_busy));
        check("HEXS",   HEXS,        m_hexs);
        check("LES",    32'(LES),    32'(m_les));
        check("POINTS", 32'(POINTS), 32'(m_points));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_in_frame && k < 300) begin
            step();
            k++;
        end
        check("idle_timeout", 32'(m_in_frame), 32'd0);
    endtask

    initial begin
        int k;
        int ng;
        int loads;
        logic [2:0] gval [4];
        int gcyc [4];

        model_reset();
        rst_n = 1'b0; req = 3'b000; hexs_in = 96'h0; les_in = 24'h0;
        points_in = 24'h0; blink_in = 24'h0; blink_tick = 1'b0;
        @(negedge clk);
        repeat (3) step();
        check("rst_HEXS", HEXS, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) step();

        // Single request: grant, load and busy timing.
        hexs_in[31:0] = 32'h1234_5678; les_in = 24'hFFFFFF; points_in = 24'h00_00_81;
        req = 3'b001;
        step();
        check("lat_grant", 32'(grant), 32'h1);
        req = 3'b000;
        step();
        check("lat_load", 32'(load), 32'h1);
        check("lat_HEXS", HEXS, 32'h1234_5678);
        check("lat_POINTS", 32'(POINTS), 32'h81);
        k = 2;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check("lat_busy_low", 32'(k), 32'd67);
        wait_idle();

        // All three requesting: round-robin order and frame spacing.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        req = 3'b111;
        ng = 0; k = 0;
        for (int i = 0; i < 4; i++) begin
            gval[i] = 3'b000;
            gcyc[i] = 0;
        end
        while (ng < 4 && k < 400) begin
            step();
            k++;
            if (grant != 3'b000) begin
                gval[ng] = grant;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        req = 3'b000;
        check("rr_count", 32'(ng), 32'd4);
        check("rr_g0", 32'(gval[0]), 32'h1);
        check("rr_g1", 32'(gval[1]), 32'h2);
        check("rr_g2", 32'(gval[2]), 32'h4);
        check("rr_g3", 32'(gval[3]), 32'h1);
        for (int i = 0; i < 3; i++) begin
            check("rr_spacing", 32'(gcyc[i+1] - gcyc[i]), 32'd71);
        end
        wait_idle();

        // Blink tick during shift triggers an ungranted refresh frame.
        les_in = 24'h00FF00; blink_in = 24'h000F00;
        req = 3'b010;
        step();
        check("blk_grant", 32'(grant), 32'h2);
        req = 3'b000;
        step();
        check("blk_LES_first", 32'(LES), 32'hFF);
        repeat (10) step();
        blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
        wait_idle();
        step();
        check("blk_ref_grant", 32'(grant), 32'h0);
        check("blk_ref_busy", 32'(busy), 32'h1);
        step();
        check("blk_ref_load", 32'(load), 32'h1);
        check("blk_ref_LES", 32'(LES), 32'hF0);
        blink_in = 24'h0;
        wait_idle();

        // Request dropped mid-shift: frame completes, nothing follows.
        req = 3'b100;
        step();
        check("drop_grant", 32'(grant), 32'h4);
        repeat (21) step();
        req = 3'b000;
        wait_idle();
        loads = 0;
        repeat (20) begin
            step();
            if (load) loads++;
        end
        check("drop_no_load", 32'(loads), 32'd0);
        check("drop_idle", 32'(busy), 32'd0);

        // Reset in the middle of shifting.
        req = 3'b001;
        step();
        check("rstm_grant", 32'(grant), 32'h1);
        req = 3'b000;
        k = 0;
        while (m_age != 46 && k < 100) begin
            step();
            k++;
        end
        rst_n = 1'b0;
        step();
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_load", 32'(load), 32'd0);
        check("rstm_HEXS", HEXS, 32'h0);
        check("rstm_LES", 32'(LES), 32'h0);
        rst_n = 1'b1;
        loads = 0;
        repeat (5) begin
            step();
            if (load) loads++;
        end
        check("rstm_no_load", 32'(loads), 32'd0);
        req = 3'b011;
        step();
        check("rstm_first_grant", 32'(grant), 32'h1);
        req = 3'b000;
        wait_idle();

        // Randomized traffic against the model.
        for (int it = 0; it < 3000; it++) begin
            req = req & ~e_grant;
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = 1'b1;
            end
            if (m_in_frame && m_age >= 3 && $urandom_range(0, 63) == 0)
                req[$urandom_range(0, 2)] = 1'b0;
            if ($urandom_range(0, 3) == 0) hexs_in = {$urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) les_in = 24'($urandom());
            if ($urandom_range(0, 3) == 0) points_in = 24'($urandom());
            if ($urandom_range(0, 7) == 0) blink_in = 24'($urandom());
            blink_tick = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 1499) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
